// File: rtl/dmem_port_model.sv
// dmem_port_model: data-memory responder for the core data port.
// Byte-strobed word array plus an in-order, fixed-latency ack queue.
module dmem_port_model #(
    parameter int DEPTH_WORDS = 4096,
    parameter int LATENCY     = 2,
    parameter int QDEPTH      = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] mem_d_addr_w,
    input  logic [31:0] mem_d_data_wr_w,
    input  logic        mem_d_rd_w,
    input  logic [3:0]  mem_d_wr_w,
    input  logic        mem_d_cacheable_w,
    input  logic [10:0] mem_d_req_tag_w,
    input  logic        mem_d_invalidate_w,
    input  logic        mem_d_writeback_w,
    input  logic        mem_d_flush_w,
    output logic        mem_d_accept_w,
    output logic        mem_d_ack_w,
    output logic        mem_d_error_w,
    output logic [31:0] mem_d_data_rd_w,
    output logic [10:0] mem_d_resp_tag_w
);

    localparam int          PW  = $clog2(QDEPTH);
    localparam int          CW  = PW + 1;
    localparam int          AW  = $clog2(DEPTH_WORDS);
    localparam logic [31:0] DW  = 32'(DEPTH_WORDS);
    localparam logic [3:0]  LAT = 4'(LATENCY);

    logic [31:0]    mem_q [DEPTH_WORDS];

    logic [10:0]    etag_q [QDEPTH];
    logic [31:0]    edat_q [QDEPTH];
    logic           eerr_q [QDEPTH];
    logic [3:0]     eage_q [QDEPTH];
    logic [QDEPTH-1:0] vld_q;
    logic [PW-1:0]  head_q;
    logic [PW-1:0]  tail_q;
    logic [CW-1:0]  cnt_q;

    logic           ack_q;
    logic           rerr_q;
    logic [31:0]    rdat_q;
    logic [10:0]    rtag_q;

    logic           req;
    logic           is_st;
    logic           is_ld;
    logic           in_rng;
    logic           push;
    logic           pop;
    logic [AW-1:0]  widx;
    logic [31:0]    push_dat;
    logic           push_err;
    logic           unused_w;

    assign unused_w = ^{mem_d_cacheable_w, mem_d_addr_w[1:0]};

    assign req = mem_d_rd_w | (|mem_d_wr_w) | mem_d_invalidate_w
               | mem_d_writeback_w | mem_d_flush_w;
    assign is_st  = |mem_d_wr_w;
    assign is_ld  = mem_d_rd_w & ~is_st;
    assign in_rng = {2'b00, mem_d_addr_w[31:2]} < DW;
    assign widx   = mem_d_addr_w[AW+1:2];

    assign mem_d_accept_w = (cnt_q != CW'(QDEPTH));
    assign push = req & mem_d_accept_w & ~rst;
    assign pop  = vld_q[head_q] & (eage_q[head_q] == LAT);

    // Response payload for the request being accepted (pre-write read).
    always_comb begin
        push_dat = 32'h0;
        push_err = 1'b0;
        if ((is_st | is_ld) & ~in_rng) begin
            push_err = 1'b1;
        end else if (is_ld) begin
            push_dat = mem_q[widx];
        end
    end

    // Byte-strobed array write; contents survive reset.
    always_ff @(posedge clk) begin
        if (push & is_st & in_rng) begin
            for (int b = 0; b < 4; b++) begin
                if (mem_d_wr_w[b]) begin
                    mem_q[widx][8*b +: 8] <= mem_d_data_wr_w[8*b +: 8];
                end
            end
        end
    end

    // Queue payload and saturating ages; validity is tracked separately.
    always_ff @(posedge clk) begin
        for (int i = 0; i < QDEPTH; i++) begin
            if (eage_q[i] != 4'hF) begin
                eage_q[i] <= eage_q[i] + 4'd1;
            end
        end
        if (push) begin
            etag_q[tail_q] <= mem_d_req_tag_w;
            edat_q[tail_q] <= push_dat;
            eerr_q[tail_q] <= push_err;
            eage_q[tail_q] <= 4'd1;
        end
    end

    // Queue control and registered response outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            vld_q  <= '0;
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= '0;
            ack_q  <= 1'b0;
            rerr_q <= 1'b0;
            rdat_q <= 32'h0;
            rtag_q <= 11'h0;
        end else begin
            ack_q <= 1'b0;
            if (pop) begin
                vld_q[head_q] <= 1'b0;
                head_q <= head_q + PW'(1);
                ack_q  <= 1'b1;
                rerr_q <= eerr_q[head_q];
                rdat_q <= edat_q[head_q];
                rtag_q <= etag_q[head_q];
            end
            if (push) begin
                vld_q[tail_q] <= 1'b1;
                tail_q <= tail_q + PW'(1);
            end
            cnt_q <= cnt_q + CW'(push) - CW'(pop);
        end
    end

    assign mem_d_ack_w      = ack_q;
    assign mem_d_error_w    = rerr_q;
    assign mem_d_data_rd_w  = rdat_q;
    assign mem_d_resp_tag_w = rtag_q;

endmodule

// File: tb/tb_dmem_port_model.sv
// tb_dmem_port_model: directed bench for dmem_port_model.
// Two instances: LATENCY=2 for functional cases, LATENCY=4 for back-pressure/reset.
module tb_dmem_port_model;

    logic        clk = 1'b0;
    logic        rst2 = 1'b1;
    logic        rst4 = 1'b1;
    logic        en2 = 1'b0;
    logic        en4 = 1'b0;
    logic [31:0] addr = '0;
    logic [31:0] wdata = '0;
    logic        rd = 1'b0;
    logic [3:0]  wr = '0;
    logic [10:0] tag = '0;
    logic        inv = 1'b0;
    logic        wb = 1'b0;
    logic        fl = 1'b0;

    logic        acc2, ack2, err2;
    logic [31:0] dat2;
    logic [10:0] tag2;
    logic        acc4, ack4, err4;
    logic [31:0] dat4;
    logic [10:0] tag4;

    typedef struct {
        logic [10:0] tag;
        logic [31:0] dat;
        logic        err;
        int          cyc;
    } ack_t;

    ack_t q2[$];
    ack_t q4[$];
    int   cyc = 0;
    int   nvec = 0;
    int   nbad = 0;

    always #5 clk = ~clk;

    dmem_port_model #(.DEPTH_WORDS(4096), .LATENCY(2), .QDEPTH(4)) u2 (
        .clk(clk), .rst(rst2),
        .mem_d_addr_w(addr), .mem_d_data_wr_w(wdata),
        .mem_d_rd_w(rd & en2), .mem_d_wr_w(wr & {4{en2}}),
        .mem_d_cacheable_w(1'b1), .mem_d_req_tag_w(tag),
        .mem_d_invalidate_w(inv & en2), .mem_d_writeback_w(wb & en2),
        .mem_d_flush_w(fl & en2),
        .mem_d_accept_w(acc2), .mem_d_ack_w(ack2), .mem_d_error_w(err2),
        .mem_d_data_rd_w(dat2), .mem_d_resp_tag_w(tag2)
    );

    dmem_port_model #(.DEPTH_WORDS(4096), .LATENCY(4), .QDEPTH(4)) u4 (
        .clk(clk), .rst(rst4),
        .mem_d_addr_w(addr), .mem_d_data_wr_w(wdata),
        .mem_d_rd_w(rd & en4), .mem_d_wr_w(wr & {4{en4}}),
        .mem_d_cacheable_w(1'b0), .mem_d_req_tag_w(tag),
        .mem_d_invalidate_w(inv & en4), .mem_d_writeback_w(wb & en4),
        .mem_d_flush_w(fl & en4),
        .mem_d_accept_w(acc4), .mem_d_ack_w(ack4), .mem_d_error_w(err4),
        .mem_d_data_rd_w(dat4), .mem_d_resp_tag_w(tag4)
    );

    always @(posedge clk) cyc <= cyc + 1;

    always @(negedge clk) begin
        if (ack2) q2.push_back('{tag2, dat2, err2, cyc});
        if (ack4) q4.push_back('{tag4, dat4, err4, cyc});
    end

    task automatic chk(input string nm, input logic [63:0] got,
                       input logic [63:0] exp);
        nvec++;
        if (got !== exp) begin
            nbad++;
            $display("FAIL %s: got %0h, want %0h", nm, got, exp);
        end
    endtask

    task automatic issue(input bit sel4, input logic r, input logic [3:0] w,
                         input logic [2:0] mnt, input logic [31:0] a,
                         input logic [31:0] d, input logic [10:0] t,
                         output int acyc);
        bit took;
        en2 = !sel4;
        en4 = sel4;
        rd = r;
        wr = w;
        {inv, wb, fl} = mnt;
        addr = a;
        wdata = d;
        tag = t;
        took = 1'b0;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            if (sel4 ? acc4 : acc2) begin
                took = 1'b1;
                break;
            end
        end
        if (!took) chk("accept_timeout", 0, 1);
        @(posedge clk);
        #1;
        acyc = cyc;
    endtask

    task automatic idle(input int n);
        en2 = 1'b0;
        en4 = 1'b0;
        rd = 1'b0;
        wr = '0;
        {inv, wb, fl} = 3'b000;
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int a0, a1, a2, a3;
        int ac[8];
        int exp_off[8];
        exp_off = '{0, 1, 2, 3, 5, 6, 7, 8};

        repeat (2) @(posedge clk);
        #1;
        rst2 = 1'b0;
        rst4 = 1'b0;
        @(negedge clk);
        chk("rst_ack", ack2, 0);
        chk("rst_err", err2, 0);
        chk("rst_dat", dat2, 0);
        chk("rst_tag", tag2, 0);
        chk("rst_acc2", acc2, 1);
        chk("rst_acc4", acc4, 1);
        @(posedge clk);
        #1;

        u2.mem_q[3] = 32'h11223344;
        u2.mem_q[0] = 32'hCAFEF00D;
        for (int k = 0; k < 8; k++) u4.mem_q[k] = 32'h100 + k;

        // store then load
        q2.delete();
        issue(0, 0, 4'hF, 3'b000, 32'h10, 32'hDEADBEEF, 11'd5, a0);
        issue(0, 1, 4'h0, 3'b000, 32'h10, 32'h0, 11'd6, a1);
        idle(6);
        chk("sl_b2b", a1 - a0, 1);
        chk("sl_nack", q2.size(), 2);
        if (q2.size() == 2) begin
            chk("sl_tag0", q2[0].tag, 5);
            chk("sl_dat0", q2[0].dat, 0);
            chk("sl_err0", q2[0].err, 0);
            chk("sl_lat0", q2[0].cyc - a0, 2);
            chk("sl_tag1", q2[1].tag, 6);
            chk("sl_dat1", q2[1].dat, 32'hDEADBEEF);
            chk("sl_lat1", q2[1].cyc - a1, 2);
        end

        // byte strobes
        q2.delete();
        issue(0, 0, 4'b0101, 3'b000, 32'hC, 32'hAABBCCDD, 11'd7, a0);
        issue(0, 1, 4'h0, 3'b000, 32'hC, 32'h0, 11'd8, a1);
        idle(6);
        chk("bs_nack", q2.size(), 2);
        if (q2.size() == 2) begin
            chk("bs_tag", q2[1].tag, 8);
            chk("bs_dat", q2[1].dat, 32'h11BB33DD);
        end

        // range error
        q2.delete();
        issue(0, 1, 4'h0, 3'b000, 32'h0001_0000, 32'h0, 11'd9, a0);
        issue(0, 0, 4'hF, 3'b000, 32'h0001_0000, 32'h12345678, 11'd10, a1);
        idle(6);
        chk("re_nack", q2.size(), 2);
        if (q2.size() == 2) begin
            chk("re_ld_err", q2[0].err, 1);
            chk("re_ld_dat", q2[0].dat, 0);
            chk("re_st_tag", q2[1].tag, 10);
            chk("re_st_err", q2[1].err, 1);
            chk("re_st_dat", q2[1].dat, 0);
        end
        chk("re_w0", u2.mem_q[0], 32'hCAFEF00D);
        chk("re_w3", u2.mem_q[3], 32'h11BB33DD);
        chk("re_w4", u2.mem_q[4], 32'hDEADBEEF);

        // maintenance flush
        q2.delete();
        issue(0, 0, 4'h0, 3'b001, 32'h10, 32'hFFFFFFFF, 11'h7FF, a0);
        idle(6);
        chk("fl_nack", q2.size(), 1);
        if (q2.size() == 1) begin
            chk("fl_tag", q2[0].tag, 11'h7FF);
            chk("fl_err", q2[0].err, 0);
            chk("fl_dat", q2[0].dat, 0);
        end
        chk("fl_w4", u2.mem_q[4], 32'hDEADBEEF);

        q2.delete();
        issue(0, 1, 4'h0, 3'b000, 32'h0, 32'h0, 11'd11, a0);
        idle(6);
        chk("w0_nack", q2.size(), 1);
        if (q2.size() == 1) begin
            chk("w0_dat", q2[0].dat, 32'hCAFEF00D);
            chk("w0_err", q2[0].err, 0);
        end

        // back-pressure, LATENCY=4
        q4.delete();
        for (int i = 0; i < 8; i++) begin
            issue(1, 1, 4'h0, 3'b000, 32'(i * 4), 32'h0, 11'(i), ac[i]);
        end
        idle(12);
        for (int i = 1; i < 8; i++) begin
            chk($sformatf("bp_acc%0d", i), ac[i] - ac[0], exp_off[i]);
        end
        chk("bp_nack", q4.size(), 8);
        if (q4.size() == 8) begin
            for (int i = 0; i < 8; i++) begin
                chk($sformatf("bp_tag%0d", i), q4[i].tag, i);
                chk($sformatf("bp_dat%0d", i), q4[i].dat, 32'h100 + i);
                chk($sformatf("bp_lat%0d", i), q4[i].cyc - ac[i], 4);
            end
        end

        // reset with requests in flight
        issue(1, 0, 4'hF, 3'b000, 32'h50, 32'h5A5A1234, 11'd1, a0);
        idle(8);
        q4.delete();
        issue(1, 1, 4'h0, 3'b000, 32'h50, 32'h0, 11'h31, a1);
        issue(1, 1, 4'h0, 3'b000, 32'h50, 32'h0, 11'h32, a2);
        issue(1, 1, 4'h0, 3'b000, 32'h50, 32'h0, 11'h33, a3);
        en4 = 1'b0;
        rd = 1'b0;
        rst4 = 1'b1;
        @(posedge clk);
        #1;
        rst4 = 1'b0;
        @(negedge clk);
        chk("mr_ack", ack4, 0);
        chk("mr_tag", tag4, 0);
        chk("mr_dat", dat4, 0);
        chk("mr_err", err4, 0);
        chk("mr_acc", acc4, 1);
        idle(8);
        chk("mr_noack", q4.size(), 0);
        q4.delete();
        issue(1, 1, 4'h0, 3'b000, 32'h50, 32'h0, 11'h40, a0);
        idle(8);
        chk("mr_nack", q4.size(), 1);
        if (q4.size() == 1) begin
            chk("mr_ld_tag", q4[0].tag, 11'h40);
            chk("mr_ld_dat", q4[0].dat, 32'h5A5A1234);
        end

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
